// File: rtl/instruction_queue.sv
// -----------------------------------------------------------------------------
// instruction_queue
//
// Fetch-block FIFO between the PC/fetch stage and decode/dispatch. Each cycle
// it can accept one aligned fetch block and unpack only its valid slots
// (first slot from the fetch PC, last slot from i_pc_pc_upperbound). It hands
// decode one instruction per cycle together with the instruction's PC, its
// predicted next PC and the global history of the block it came from. A
// branch mispredict empties the queue.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_branch_valid               branch resolution valid
//   i_branch_correct_prediction  low together with i_branch_valid = flush
//   i_pc_valid / o_pc_ready      fetch block handshake
//   i_pc_instruction_flatten     slot i at [i*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA]
//   i_pc_pc                      fetch PC; bits [BW_PC_MOD+1:2] = first valid slot
//   i_pc_pc_upperbound           last valid slot of the block
//   i_pc_pc_next_flatten         predicted next PC per slot
//   i_pc_global_history          global history for the whole block
//   o_dec_valid / i_dec_ready    decode handshake for the head entry
//   o_dec_instruction, o_dec_pc, o_dec_pc_next, o_dec_global_history
//                                head entry contents
//   o_count                      number of occupied entries
// -----------------------------------------------------------------------------
module instruction_queue #(
    parameter int BW_PROCESSOR_DATA    = 32,
    parameter int BW_PROCESSOR_BLOCK   = 64,
    parameter int BW_ADDRESS           = 32,
    parameter int NUM_GLOBAL_HISTORY   = 4,
    parameter int NUM_IQ_ENTRY         = 8,
    parameter int NUM_FIFO_INPUT_ENTRY = BW_PROCESSOR_BLOCK / BW_PROCESSOR_DATA,
    parameter int BW_PC_MOD            = $clog2(NUM_FIFO_INPUT_ENTRY) + ((NUM_FIFO_INPUT_ENTRY <= 1) ? 1 : 0)
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       i_branch_valid,
    input  logic                                       i_branch_correct_prediction,
    input  logic                                       i_pc_valid,
    output logic                                       o_pc_ready,
    input  logic [BW_PROCESSOR_BLOCK-1:0]              i_pc_instruction_flatten,
    input  logic [BW_ADDRESS-1:0]                      i_pc_pc,
    input  logic [BW_PC_MOD-1:0]                       i_pc_pc_upperbound,
    input  logic [NUM_FIFO_INPUT_ENTRY*BW_ADDRESS-1:0] i_pc_pc_next_flatten,
    input  logic [NUM_GLOBAL_HISTORY-1:0]              i_pc_global_history,
    output logic                                       o_dec_valid,
    input  logic                                       i_dec_ready,
    output logic [BW_PROCESSOR_DATA-1:0]               o_dec_instruction,
    output logic [BW_ADDRESS-1:0]                      o_dec_pc,
    output logic [BW_ADDRESS-1:0]                      o_dec_pc_next,
    output logic [NUM_GLOBAL_HISTORY-1:0]              o_dec_global_history,
    output logic [$clog2(NUM_IQ_ENTRY):0]              o_count
);

    localparam int PTR_W = $clog2(NUM_IQ_ENTRY);
    localparam int CNT_W = PTR_W + 1;
    localparam int NFI   = NUM_FIFO_INPUT_ENTRY;

    logic [PTR_W-1:0]              r_rd_ptr;
    logic [PTR_W-1:0]              r_wr_ptr;
    logic [CNT_W-1:0]              r_count;

    logic [BW_PROCESSOR_DATA-1:0]  r_instr [NUM_IQ_ENTRY];
    logic [BW_ADDRESS-1:0]         r_pc    [NUM_IQ_ENTRY];
    logic [BW_ADDRESS-1:0]         r_pcn   [NUM_IQ_ENTRY];
    logic [NUM_GLOBAL_HISTORY-1:0] r_gh    [NUM_IQ_ENTRY];

    logic                          w_flush;
    logic                          w_push;
    logic                          w_pop;
    logic [BW_PC_MOD-1:0]          w_first_slot;
    logic [CNT_W-1:0]              w_push_n;

    logic [BW_PROCESSOR_DATA-1:0]  w_blk_instr [NFI];
    logic [BW_ADDRESS-1:0]         w_blk_pcn   [NFI];

    logic                          w_wr_en    [NFI];
    logic [PTR_W-1:0]              w_wr_idx   [NFI];
    logic [BW_PC_MOD-1:0]          w_slot     [NFI];
    logic [BW_ADDRESS-1:0]         w_entry_pc [NFI];

    // Byte-offset bits of the fetch PC carry no information for the queue.
    logic                          w_unused_pc_bits;
    assign w_unused_pc_bits = &{1'b0, i_pc_pc[1:0]};

    assign w_flush      = i_branch_valid && !i_branch_correct_prediction;
    assign o_pc_ready   = !w_flush && (r_count <= CNT_W'(NUM_IQ_ENTRY - NFI));
    assign o_dec_valid  = (r_count != '0);
    assign w_push       = i_pc_valid && o_pc_ready;
    assign w_pop        = o_dec_valid && i_dec_ready;
    assign w_first_slot = i_pc_pc[BW_PC_MOD+1:2];

    // An upper bound below the first slot means an empty block: it is
    // consumed by the handshake but writes nothing.
    assign w_push_n = (i_pc_pc_upperbound >= w_first_slot)
                    ? (CNT_W'(i_pc_pc_upperbound) - CNT_W'(w_first_slot) + CNT_W'(1))
                    : '0;

    for (genvar j = 0; j < NFI; j++) begin : g_unpack
        assign w_blk_instr[j] = i_pc_instruction_flatten[j*BW_PROCESSOR_DATA +: BW_PROCESSOR_DATA];
        assign w_blk_pcn[j]   = i_pc_pc_next_flatten[j*BW_ADDRESS +: BW_ADDRESS];
    end

    // Write port k takes block slot first_slot+k into queue entry wr_ptr+k;
    // the pointer add wraps naturally, so a block may straddle the end.
    always_comb begin
        for (int k = 0; k < NFI; k++) begin
            w_slot[k]     = w_first_slot + BW_PC_MOD'(k);
            w_wr_en[k]    = w_push && (CNT_W'(k) < w_push_n);
            w_wr_idx[k]   = r_wr_ptr + PTR_W'(k);
            w_entry_pc[k] = {i_pc_pc[BW_ADDRESS-1:BW_PC_MOD+2], w_slot[k], 2'b00};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NUM_IQ_ENTRY; e++) begin
                r_instr[e] <= '0;
                r_pc[e]    <= '0;
                r_pcn[e]   <= '0;
                r_gh[e]    <= '0;
            end
        end else begin
            for (int k = 0; k < NFI; k++) begin
                if (w_wr_en[k]) begin
                    r_instr[w_wr_idx[k]] <= w_blk_instr[w_slot[k]];
                    r_pc[w_wr_idx[k]]    <= w_entry_pc[k];
                    r_pcn[w_wr_idx[k]]   <= w_blk_pcn[w_slot[k]];
                    r_gh[w_wr_idx[k]]    <= i_pc_global_history;
                end
            end
        end
    end

    // Flush wins over any push/pop; push is already blocked by o_pc_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_n);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + (w_push ? w_push_n : CNT_W'(0)) - (w_pop ? CNT_W'(1) : CNT_W'(0));
        end
    end

    assign o_dec_instruction    = r_instr[r_rd_ptr];
    assign o_dec_pc             = r_pc[r_rd_ptr];
    assign o_dec_pc_next        = r_pcn[r_rd_ptr];
    assign o_dec_global_history = r_gh[r_rd_ptr];
    assign o_count              = r_count;

endmodule

// File: tb/tb_instruction_queue.sv
module tb_instruction_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_branch_valid;
    logic        i_branch_correct_prediction;
    logic        i_pc_valid;
    logic        o_pc_ready;
    logic [63:0] i_pc_instruction_flatten;
    logic [31:0] i_pc_pc;
    logic [0:0]  i_pc_pc_upperbound;
    logic [63:0] i_pc_pc_next_flatten;
    logic [3:0]  i_pc_global_history;
    logic        o_dec_valid;
    logic        i_dec_ready;
    logic [31:0] o_dec_instruction;
    logic [31:0] o_dec_pc;
    logic [31:0] o_dec_pc_next;
    logic [3:0]  o_dec_global_history;
    logic [3:0]  o_count;

    int vectors = 0;
    int miscompares = 0;

    instruction_queue dut (
        .clk                         (clk),
        .rst                         (rst),
        .i_branch_valid              (i_branch_valid),
        .i_branch_correct_prediction (i_branch_correct_prediction),
        .i_pc_valid                  (i_pc_valid),
        .o_pc_ready                  (o_pc_ready),
        .i_pc_instruction_flatten    (i_pc_instruction_flatten),
        .i_pc_pc                     (i_pc_pc),
        .i_pc_pc_upperbound          (i_pc_pc_upperbound),
        .i_pc_pc_next_flatten        (i_pc_pc_next_flatten),
        .i_pc_global_history         (i_pc_global_history),
        .o_dec_valid                 (o_dec_valid),
        .i_dec_ready                 (i_dec_ready),
        .o_dec_instruction           (o_dec_instruction),
        .o_dec_pc                    (o_dec_pc),
        .o_dec_pc_next               (o_dec_pc_next),
        .o_dec_global_history        (o_dec_global_history),
        .o_count                     (o_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_block(input logic [31:0] pc, input logic ub, input logic [63:0] instr,
                               input logic [63:0] nxt, input logic [3:0] gh);
        i_pc_valid               = 1'b1;
        i_pc_pc                  = pc;
        i_pc_pc_upperbound       = ub;
        i_pc_instruction_flatten = instr;
        i_pc_pc_next_flatten     = nxt;
        i_pc_global_history      = gh;
    endtask

    task automatic idle();
        i_pc_valid = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0d want 0", o_dec_valid); end
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", o_count); end
        vectors++; if (o_pc_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %0d want 1", o_pc_ready); end
        vectors++; if (o_dec_instruction !== 32'h0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", o_dec_instruction); end
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL post_reset_count: got %0d want 0", o_count); end
    endtask

    task automatic test_basic();
        i_dec_ready = 1'b0;
        drive_block(32'h0, 1'b1, {32'hBBBB_BBBB, 32'hAAAA_AAAA}, {32'h8, 32'h4}, 4'b0011);
        #1;
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_bypass: got %0d want 0", o_dec_valid); end
        tick();
        idle();
        vectors++; if (o_count !== 4'd2) begin miscompares++; $display("FAIL basic_count: got %0d want 2", o_count); end
        vectors++; if (o_dec_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid: got %0d want 1", o_dec_valid); end
        vectors++; if (o_dec_instruction !== 32'hAAAA_AAAA) begin miscompares++; $display("FAIL basic_instr0: got %h want aaaaaaaa", o_dec_instruction); end
        vectors++; if (o_dec_pc !== 32'h0) begin miscompares++; $display("FAIL basic_pc0: got %h want 0", o_dec_pc); end
        vectors++; if (o_dec_pc_next !== 32'h4) begin miscompares++; $display("FAIL basic_next0: got %h want 4", o_dec_pc_next); end
        vectors++; if (o_dec_global_history !== 4'b0011) begin miscompares++; $display("FAIL basic_gh: got %b want 0011", o_dec_global_history); end
        tick();
        vectors++; if (o_dec_instruction !== 32'hAAAA_AAAA) begin miscompares++; $display("FAIL basic_stall_hold: got %h want aaaaaaaa", o_dec_instruction); end
        i_dec_ready = 1'b1;
        tick();
        vectors++; if (o_count !== 4'd1) begin miscompares++; $display("FAIL basic_count1: got %0d want 1", o_count); end
        vectors++; if (o_dec_instruction !== 32'hBBBB_BBBB) begin miscompares++; $display("FAIL basic_instr1: got %h want bbbbbbbb", o_dec_instruction); end
        vectors++; if (o_dec_pc !== 32'h4) begin miscompares++; $display("FAIL basic_pc1: got %h want 4", o_dec_pc); end
        vectors++; if (o_dec_pc_next !== 32'h8) begin miscompares++; $display("FAIL basic_next1: got %h want 8", o_dec_pc_next); end
        tick();
        tick();
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL basic_empty_count: got %0d want 0", o_count); end
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL basic_empty_valid: got %0d want 0", o_dec_valid); end
        i_dec_ready = 1'b0;
    endtask

    task automatic test_mid_start();
        drive_block(32'h4, 1'b1, {32'hCCCC_CCCC, 32'hDDDD_DDDD}, {32'h8, 32'h111}, 4'd5);
        tick();
        idle();
        vectors++; if (o_count !== 4'd1) begin miscompares++; $display("FAIL mid_count: got %0d want 1", o_count); end
        vectors++; if (o_dec_pc !== 32'h4) begin miscompares++; $display("FAIL mid_pc: got %h want 4", o_dec_pc); end
        vectors++; if (o_dec_pc_next !== 32'h8) begin miscompares++; $display("FAIL mid_next: got %h want 8", o_dec_pc_next); end
        vectors++; if (o_dec_instruction !== 32'hCCCC_CCCC) begin miscompares++; $display("FAIL mid_instr: got %h want cccccccc", o_dec_instruction); end
        i_dec_ready = 1'b1;
        tick();
        i_dec_ready = 1'b0;
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL mid_drain: got %0d want 0", o_count); end
    endtask

    task automatic test_fill_wrap();
        logic [31:0] exp_instr;
        i_dec_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_block(32'h100 + 32'(8 * k), 1'b1,
                        {32'h1000 + 32'(2 * k + 1), 32'h1000 + 32'(2 * k)}, 64'h0, 4'h0);
            tick();
            if (k == 2) begin
                vectors++; if (o_count !== 4'd6) begin miscompares++; $display("FAIL fill_count6: got %0d want 6", o_count); end
                vectors++; if (o_pc_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready6: got %0d want 1", o_pc_ready); end
            end
        end
        idle();
        vectors++; if (o_count !== 4'd8) begin miscompares++; $display("FAIL fill_count8: got %0d want 8", o_count); end
        vectors++; if (o_pc_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready8: got %0d want 0", o_pc_ready); end
        drive_block(32'h300, 1'b1, {32'h9999_9999, 32'h9999_9998}, 64'h0, 4'h0);
        tick();
        idle();
        vectors++; if (o_count !== 4'd8) begin miscompares++; $display("FAIL full_reject: got %0d want 8", o_count); end
        i_dec_ready = 1'b1;
        vectors++; if (o_dec_instruction !== 32'h1000) begin miscompares++; $display("FAIL fill_pop0: got %h want 1000", o_dec_instruction); end
        tick();
        vectors++; if (o_dec_instruction !== 32'h1001) begin miscompares++; $display("FAIL fill_pop1: got %h want 1001", o_dec_instruction); end
        tick();
        i_dec_ready = 1'b0;
        vectors++; if (o_count !== 4'd6) begin miscompares++; $display("FAIL fill_after_pop: got %0d want 6", o_count); end
        vectors++; if (o_pc_ready !== 1'b1) begin miscompares++; $display("FAIL fill_ready_again: got %0d want 1", o_pc_ready); end
        drive_block(32'h200, 1'b1, {32'h2001, 32'h2000}, 64'h0, 4'h0);
        tick();
        idle();
        vectors++; if (o_count !== 4'd8) begin miscompares++; $display("FAIL wrap_count: got %0d want 8", o_count); end
        i_dec_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_instr = (i < 6) ? 32'h1002 + 32'(i) : 32'h2000 + 32'(i - 6);
            vectors++;
            if (o_dec_instruction !== exp_instr) begin
                miscompares++;
                $display("FAIL wrap_order[%0d]: got %h want %h", i, o_dec_instruction, exp_instr);
            end
            tick();
        end
        i_dec_ready = 1'b0;
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL wrap_drain: got %0d want 0", o_dec_valid); end
    endtask

    task automatic test_taken();
        drive_block(32'h8, 1'b0, {32'hEEEE_EEEE, 32'hFFFF_FFFF}, {32'hDEAD, 32'h40}, 4'b1010);
        tick();
        idle();
        vectors++; if (o_count !== 4'd1) begin miscompares++; $display("FAIL taken_count: got %0d want 1", o_count); end
        vectors++; if (o_dec_pc !== 32'h8) begin miscompares++; $display("FAIL taken_pc: got %h want 8", o_dec_pc); end
        vectors++; if (o_dec_pc_next !== 32'h40) begin miscompares++; $display("FAIL taken_next: got %h want 40", o_dec_pc_next); end
        vectors++; if (o_dec_global_history !== 4'b1010) begin miscompares++; $display("FAIL taken_gh: got %b want 1010", o_dec_global_history); end
        vectors++; if (o_dec_instruction !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL taken_instr: got %h want ffffffff", o_dec_instruction); end
        i_dec_ready = 1'b1;
        tick();
        i_dec_ready = 1'b0;
        // Upper bound below the first slot: nothing is enqueued.
        drive_block(32'h4, 1'b0, {32'h5555_5555, 32'h6666_6666}, 64'h0, 4'h0);
        tick();
        idle();
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL empty_block_count: got %0d want 0", o_count); end
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL empty_block_valid: got %0d want 0", o_dec_valid); end
    endtask

    task automatic test_push_pop();
        i_dec_ready = 1'b0;
        drive_block(32'h20, 1'b1, {32'h3001, 32'h3000}, 64'h0, 4'h0);
        tick();
        drive_block(32'h2C, 1'b1, {32'h3003, 32'h3002}, 64'h0, 4'h0);
        tick();
        idle();
        vectors++; if (o_count !== 4'd3) begin miscompares++; $display("FAIL pp_count3: got %0d want 3", o_count); end
        vectors++; if (o_dec_instruction !== 32'h3000) begin miscompares++; $display("FAIL pp_head: got %h want 3000", o_dec_instruction); end
        drive_block(32'h30, 1'b1, {32'h3005, 32'h3004}, 64'h0, 4'h0);
        i_dec_ready = 1'b1;
        tick();
        idle();
        i_dec_ready = 1'b0;
        vectors++; if (o_count !== 4'd4) begin miscompares++; $display("FAIL pp_count4: got %0d want 4", o_count); end
        vectors++; if (o_dec_instruction !== 32'h3001) begin miscompares++; $display("FAIL pp_head2: got %h want 3001", o_dec_instruction); end
    endtask

    task automatic test_flush();
        drive_block(32'h44, 1'b1, {32'h3007, 32'h3006}, 64'h0, 4'h0);
        tick();
        idle();
        vectors++; if (o_count !== 4'd5) begin miscompares++; $display("FAIL flush_pre_count: got %0d want 5", o_count); end
        i_branch_valid = 1'b1;
        i_branch_correct_prediction = 1'b1;
        #1;
        vectors++; if (o_pc_ready !== 1'b1) begin miscompares++; $display("FAIL correct_pred_ready: got %0d want 1", o_pc_ready); end
        i_branch_correct_prediction = 1'b0;
        drive_block(32'h50, 1'b1, {32'h7777_7777, 32'h8888_8888}, 64'h0, 4'h0);
        #1;
        vectors++; if (o_pc_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready: got %0d want 0", o_pc_ready); end
        tick();
        idle();
        i_branch_valid = 1'b0;
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL flush_count: got %0d want 0", o_count); end
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid: got %0d want 0", o_dec_valid); end
        tick();
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL flush_no_enqueue: got %0d want 0", o_count); end
        vectors++; if (o_pc_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready_after: got %0d want 1", o_pc_ready); end
    endtask

    task automatic test_reset_mid();
        drive_block(32'h60, 1'b1, {32'h4001, 32'h4000}, {32'h68, 32'h64}, 4'h7);
        tick();
        idle();
        vectors++; if (o_count !== 4'd2) begin miscompares++; $display("FAIL rmid_pre_count: got %0d want 2", o_count); end
        vectors++; if (o_dec_instruction !== 32'h4000) begin miscompares++; $display("FAIL rmid_pre_instr: got %h want 4000", o_dec_instruction); end
        #2;
        rst = 1'b1;
        #1;
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL rmid_count: got %0d want 0", o_count); end
        vectors++; if (o_dec_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_valid: got %0d want 0", o_dec_valid); end
        vectors++; if (o_dec_instruction !== 32'h0) begin miscompares++; $display("FAIL rmid_instr: got %h want 0", o_dec_instruction); end
        vectors++; if (o_dec_pc !== 32'h0) begin miscompares++; $display("FAIL rmid_pc: got %h want 0", o_dec_pc); end
        vectors++; if (o_dec_pc_next !== 32'h0) begin miscompares++; $display("FAIL rmid_next: got %h want 0", o_dec_pc_next); end
        vectors++; if (o_dec_global_history !== 4'h0) begin miscompares++; $display("FAIL rmid_gh: got %h want 0", o_dec_global_history); end
        vectors++; if (o_pc_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready: got %0d want 1", o_pc_ready); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (o_count !== 4'd0) begin miscompares++; $display("FAIL rmid_after: got %0d want 0", o_count); end
    endtask

    initial begin
        rst                         = 1'b1;
        i_branch_valid              = 1'b0;
        i_branch_correct_prediction = 1'b0;
        i_pc_valid                  = 1'b0;
        i_pc_instruction_flatten    = '0;
        i_pc_pc                     = '0;
        i_pc_pc_upperbound          = '0;
        i_pc_pc_next_flatten        = '0;
        i_pc_global_history         = '0;
        i_dec_ready                 = 1'b0;

        test_reset();
        test_basic();
        test_mid_start();
        test_fill_wrap();
        test_taken();
        test_push_pop();
        test_flush();
        test_reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
